// File: rtl/sync_sram.sv
// rtl/sync_sram.sv - clocked single-port SRAM with byte lanes and a 1/2-stage read pipeline
// Optional power-on clear sweep is compiled in with SYNC_SRAM_CLEAR_EN.
module sync_sram #(
   parameter int AddressSize = 6,
   parameter int WordSize    = 8,
   parameter int ReadLatency = 1
) (
   input  logic                     Clk,
   input  logic                     bReset,
   input  logic                     bCE,
   input  logic                     bWE,
   input  logic [AddressSize-1:0]   Address,
   input  logic [WordSize-1:0]      InData,
   input  logic [WordSize/8-1:0]    ByteEn,
   output logic                     Ready,
   output logic [WordSize-1:0]      OutData,
   output logic                     OutValid
);

   localparam int Depth = 2**AddressSize;
   localparam int Lanes = WordSize/8;

   logic [WordSize-1:0] mem [Depth];

   logic                rdAccept;
   logic                wrAccept;
   logic                s0Valid;
   logic [WordSize-1:0] s0Data;
   logic                s1Valid;
   logic [WordSize-1:0] s1Data;

   assign rdAccept = !bCE && Ready && bWE;
   assign wrAccept = !bCE && Ready && !bWE;

`ifdef SYNC_SRAM_CLEAR_EN
   typedef enum logic {CLEAR, RUN} state_t;

   state_t                 state;
   logic [AddressSize-1:0] clrAddr;

   always_ff @(posedge Clk or negedge bReset) begin
      if (!bReset) begin
         state   <= CLEAR;
         clrAddr <= '0;
         Ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clrAddr <= clrAddr + 1'b1;
               if (clrAddr == AddressSize'(Depth-1)) begin
                  state <= RUN;
                  Ready <= 1'b1;
               end
            end
            RUN: Ready <= 1'b1;
            default: begin
               state <= RUN;
               Ready <= 1'b1;
            end
         endcase
      end
   end
`else
   assign Ready = 1'b1;
`endif

   // Storage has no reset so that contents survive bReset when the sweep is absent.
   always_ff @(posedge Clk) begin
`ifdef SYNC_SRAM_CLEAR_EN
      if (state == CLEAR)
         mem[clrAddr] <= '0;
      else
`endif
      if (wrAccept) begin
         for (int i = 0; i < Lanes; i++) begin
            if (ByteEn[i])
               mem[Address][8*i +: 8] <= InData[8*i +: 8];
         end
      end
   end

   // Stage 0 captures the word on the accepting edge; OutValid follows ReadLatency edges later.
   always_ff @(posedge Clk or negedge bReset) begin
      if (!bReset) begin
         s0Valid  <= 1'b0;
         s0Data   <= '0;
         s1Valid  <= 1'b0;
         s1Data   <= '0;
         OutValid <= 1'b0;
         OutData  <= '0;
      end else begin
         s0Valid <= rdAccept;
         if (rdAccept)
            s0Data <= mem[Address];
         if (ReadLatency == 1) begin
            OutValid <= s0Valid;
            if (s0Valid)
               OutData <= s0Data;
         end else begin
            s1Valid <= s0Valid;
            if (s0Valid)
               s1Data <= s0Data;
            OutValid <= s1Valid;
            if (s1Valid)
               OutData <= s1Data;
         end
      end
   end

endmodule

// File: tb/tb_sync_sram.sv
// tb/tb_sync_sram.sv - scoreboard bench for sync_sram, default and 32-bit/latency-2 instances
module tb_sync_sram;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        bReset = 1'b0;
   logic        ceA = 1'b1, weA = 1'b1;
   logic [5:0]  addrA = '0;
   logic [7:0]  dinA = '0;
   logic [0:0]  beA = '0;
   logic        readyA, outValidA;
   logic [7:0]  outDataA;
   logic        ceB = 1'b1, weB = 1'b1;
   logic [5:0]  addrB = '0;
   logic [31:0] dinB = '0;
   logic [3:0]  beB = '0;
   logic        readyB, outValidB;
   logic [31:0] outDataB;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t qA[$];
   exp_t qB[$];
   exp_t eA, eB;
   logic [7:0]  lastA = '0;
   logic [31:0] lastB = '0;

   sync_sram dutA (
      .Clk(clk), .bReset(bReset), .bCE(ceA), .bWE(weA), .Address(addrA),
      .InData(dinA), .ByteEn(beA), .Ready(readyA), .OutData(outDataA), .OutValid(outValidA)
   );

   sync_sram #(.AddressSize(6), .WordSize(32), .ReadLatency(2)) dutB (
      .Clk(clk), .bReset(bReset), .bCE(ceB), .bWE(weB), .Address(addrB),
      .InData(dinB), .ByteEn(beB), .Ready(readyB), .OutData(outDataB), .OutValid(outValidB)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (outValidA) begin
         checks++;
         if (qA.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid_A data=%h cyc=%0d", outDataA, cyc);
         end else begin
            eA = qA.pop_front();
            lastA = eA.data[7:0];
            if (outDataA !== eA.data[7:0] || cyc != eA.due) begin
               errors++;
               $display("FAIL read_A got %h at cyc %0d, want %h at cyc %0d",
                        outDataA, cyc, eA.data[7:0], eA.due);
            end
         end
      end
      if (outValidB) begin
         checks++;
         if (qB.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid_B data=%h cyc=%0d", outDataB, cyc);
         end else begin
            eB = qB.pop_front();
            lastB = eB.data;
            if (outDataB !== eB.data || cyc != eB.due) begin
               errors++;
               $display("FAIL read_B got %h at cyc %0d, want %h at cyc %0d",
                        outDataB, cyc, eB.data, eB.due);
            end
         end
      end
   end

   task automatic wrA(input logic [5:0] a, input logic [7:0] d, input logic be);
      ceA = 1'b0; weA = 1'b0; addrA = a; dinA = d; beA = be;
      @(negedge clk);
      ceA = 1'b1; weA = 1'b1;
   endtask

   task automatic rdA(input logic [5:0] a, input logic [7:0] d);
      exp_t e;
      ceA = 1'b0; weA = 1'b1; addrA = a;
      e.data = 32'(d); e.due = cyc + 2;
      qA.push_back(e);
      @(negedge clk);
      ceA = 1'b1;
   endtask

   task automatic wrB(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      ceB = 1'b0; weB = 1'b0; addrB = a; dinB = d; beB = be;
      @(negedge clk);
      ceB = 1'b1; weB = 1'b1;
   endtask

   task automatic rdB(input logic [5:0] a, input logic [31:0] d);
      exp_t e;
      ceB = 1'b0; weB = 1'b1; addrB = a;
      e.data = d; e.due = cyc + 3;
      qB.push_back(e);
      @(negedge clk);
      ceB = 1'b1;
   endtask

   task automatic drain(input string name);
      repeat (5) @(negedge clk);
      checks++;
      if (qA.size() != 0 || qB.size() != 0) begin
         errors++;
         $display("FAIL drain_%s pending A=%0d B=%0d, want 0", name, qA.size(), qB.size());
         qA.delete(); qB.delete();
      end
   endtask

   task automatic test_reset;
      logic expReady;
`ifdef SYNC_SRAM_CLEAR_EN
      expReady = 1'b0;
`else
      expReady = 1'b1;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (outValidA !== 1'b0 || outValidB !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b%b want 00", outValidA, outValidB);
      end
      checks++;
      if (outDataA !== 8'h00 || outDataB !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h want 0", outDataA, outDataB);
      end
      checks++;
      if (readyA !== expReady || readyB !== expReady) begin
         errors++;
         $display("FAIL reset_ready got %b%b want %b", readyA, readyB, expReady);
      end
   endtask

   task automatic test_clear;
      int n = 0;
      bReset = 1'b1;
`ifdef SYNC_SRAM_CLEAR_EN
      wrA(6'd2, 8'hFF, 1'b1);
      wrB(6'd2, 32'hFFFF_FFFF, 4'hF);
      n = 2;
      checks++;
      if (readyA !== 1'b0) begin
         errors++;
         $display("FAIL clear_ready_low got %b want 0", readyA);
      end
`endif
      while (!(readyA && readyB) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
`ifdef SYNC_SRAM_CLEAR_EN
      if (n != 64) begin
         errors++;
         $display("FAIL clear_duration got %0d want 64", n);
      end
      rdA(6'h3F, 8'h00);
      rdA(6'd2, 8'h00);
      rdB(6'd2, 32'h0);
      rdB(6'h3F, 32'h0);
`else
      if (n != 0) begin
         errors++;
         $display("FAIL ready_immediate got %0d want 0", n);
      end
`endif
      drain("clear");
   endtask

   task automatic test_byte_mask;
      wrB(6'd5, 32'hAABBCCDD, 4'b1111);
      wrB(6'd5, 32'h11223344, 4'b0101);
      rdB(6'd5, 32'hAA22CC44);
      wrA(6'd9, 8'h77, 1'b1);
      wrA(6'd9, 8'h00, 1'b0);
      rdA(6'd9, 8'h77);
      drain("byte_mask");
   endtask

   task automatic test_pipelined;
      wrB(6'd1, 32'h10, 4'hF);
      wrB(6'd2, 32'h20, 4'hF);
      wrB(6'd3, 32'h30, 4'hF);
      rdB(6'd1, 32'h10);
      rdB(6'd2, 32'h20);
      rdB(6'd3, 32'h30);
      drain("pipelined");
   endtask

   task automatic test_raw;
      wrA(6'd7, 8'h5A, 1'b1);
      rdA(6'd7, 8'h5A);
      wrB(6'd7, 32'hDEAD_BEEF, 4'hF);
      rdB(6'd7, 32'hDEAD_BEEF);
      drain("raw");
   endtask

   task automatic test_sweep;
      for (int i = 0; i < 64; i++) wrA(6'(i), 8'(i) ^ 8'hC3, 1'b1);
      for (int i = 0; i < 64; i++) rdA(6'(i), 8'(i) ^ 8'hC3);
      wrA(6'd7, 8'h5A, 1'b1);
      drain("sweep");
   endtask

   task automatic test_gating;
      logic [7:0] holdA;
      holdA = lastA;
      ceA = 1'b1; weA = 1'b1; addrA = 6'd9;
      repeat (4) @(negedge clk);
      checks++;
      if (outDataA !== holdA) begin
         errors++;
         $display("FAIL gated_read_data got %h want %h", outDataA, holdA);
      end
      drain("gating");
   endtask

   task automatic test_reset_mid_read;
      int n = 0;
      logic [7:0]  expA;
      logic [31:0] expB;
      ceA = 1'b0; weA = 1'b1; addrA = 6'd7;
      ceB = 1'b0; weB = 1'b1; addrB = 6'd5;
      @(posedge clk);
      #1 bReset = 1'b0;
      ceA = 1'b1; ceB = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (outValidA !== 1'b0 || outValidB !== 1'b0 || outDataA !== 8'h0 || outDataB !== 32'h0) begin
            errors++;
            $display("FAIL mid_read_reset valid=%b%b data=%h %h want 0", outValidA, outValidB,
                     outDataA, outDataB);
         end
      end
      bReset = 1'b1;
      while (!(readyA && readyB) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(readyA && readyB)) begin
         errors++;
         $display("FAIL ready_after_reset got %b%b want 11", readyA, readyB);
      end
`ifdef SYNC_SRAM_CLEAR_EN
      expA = 8'h00; expB = 32'h0;
`else
      expA = 8'h5A; expB = 32'hAA22CC44;
`endif
      rdA(6'd7, expA);
      rdB(6'd5, expB);
      drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_clear();
      test_byte_mask();
      test_pipelined();
      test_raw();
      test_sweep();
      test_gating();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_sram.md
# sync_sram

Synchronous, parametrised single-port SRAM for the memory subsystem and the next generation of the team's asynchronous SRAM model. It replaces level-sensitive access with clocked requests, adds per-byte write masking, a configurable read pipeline, and a read-valid strobe. It sits between bus-side controllers and on-chip storage, and is fully pipelined at one request per cycle.

## Interface
- AddressSize, 6, address width; Depth = 2**AddressSize words.
- WordSize, 8, data width in bits; must be a multiple of 8; Lanes = WordSize/8.
- ReadLatency, 1, number of cycles from read acceptance to OutValid; legal values are 1 and 2.

- Clk  in  1  single clock; all state changes on the rising edge.
- bReset  in  1  asynchronous, active-low reset.
- bCE  in  1  active-low request strobe.
- bWE  in  1  access type: 0 = write, 1 = read; sampled with bCE.
- Address  in  AddressSize  word address.
- InData  in  WordSize  write data.
- ByteEn  in  Lanes  active-high write lane mask; lane i covers InData[8i+7:8i].
- Ready  out  1  high when requests are accepted.
- OutData  out  WordSize  read data.
- OutValid  out  1  one-cycle pulse marking OutData as a new read result.

## Operation
- A request is accepted on a rising Clk edge when bCE=0 and Ready=1. When Ready=0, bCE is ignored and the request is dropped.
- **Write** (bWE=0):
  - Lanes with ByteEn=1 take InData; other lanes keep their old value.
  - ByteEn=0 on all lanes is a legal no-op.
  - A write produces no response.
- **Read** (bWE=1):
  - Returns the word at Address.
  - OutValid pulses exactly ReadLatency cycles after acceptance.
  - OutData holds the last read result until the next read completes; it is never driven to Z.
- Single port: each cycle carries at most one access.
- Back-to-back read-after-write to the same address returns the new data.
- A read and a write accepted in the same cycle is impossible by construction.
- All Depth addresses are valid; no out-of-range case exists.
- **State machine**:
  - States CLEAR and RUN.
  - Reset enters CLEAR if the clear feature is compiled in, otherwise RUN.
  - CLEAR writes 0 to the word at counter ClrAddr, increments it each cycle, and moves to RUN after address Depth-1 is written.
  - RUN stays in RUN until reset.
  - Ready = (state == RUN).

## Timing
- **Reset values:** OutData = 0, OutValid = 0, read pipeline empty, ClrAddr = 0. Ready = 0 with the clear feature, 1 without it.
- **Reset asserted mid-operation:** in-flight reads are discarded, so no OutValid follows. An in-progress clear restarts from address 0.
- **Read latency 1:** request accepted at edge N gives OutValid=1 and OutData valid after edge N+1.
- **Read latency 2:** the same request gives OutValid=1 after edge N+2.
- **Consecutive reads** at edges N, N+1, N+2 produce OutValid high for three consecutive cycles, in request order.
- **Write visibility:** a write at edge N is visible to a read accepted at edge N+1.
- **Clear duration:** with the clear feature, Ready rises Depth cycles after bReset deasserts (64 cycles at default parameters).

## Configuration
- Macro: SYNC_SRAM_CLEAR_EN.
- **Defined:**
  - The CLEAR state and ClrAddr counter exist.
  - After every reset, memory is zeroed and Ready is held low for Depth cycles.
- **Undefined:**
  - No CLEAR state and no counter.
  - Ready is 1 immediately out of reset.
  - Memory contents are unchanged by reset: X after power-up, prior contents preserved across resets.

## Test plan
- **Clear sweep** (macro defined, defaults): release bReset, then read address 0x3F at the first Ready cycle -> Ready rises at cycle 64; read returns 0x00 with OutValid one cycle later.
- **Byte mask** (WordSize=32):
  - Write 0xAABBCCDD to address 5 with ByteEn=1111, then write 0x11223344 with ByteEn=0101.
  - Read address 5 -> OutData=0xAA22CC44.
- **Pipelined reads** (ReadLatency=2):
  - Write 0x10, 0x20, 0x30 to addresses 1, 2, 3; then read 1, 2, 3 on consecutive edges.
  - Expect OutValid high for 3 cycles starting 2 cycles after the first read, with data 0x10, 0x20, 0x30 in order.
- **Read-after-write hazard:** write 0x5A to address 7 at edge N, read address 7 at edge N+1 -> OutData=0x5A.
- **Gating:**
  - During CLEAR, assert bCE=0, bWE=0, Address=2, InData=0xFF -> ignored; address 2 reads 0x00 after Ready.
  - A read with bCE=1 -> no OutValid; OutData unchanged.
- **Reset mid-read:** accept a read, assert bReset before OutValid -> OutValid stays 0; OutData=0.
